// File: rtl/sr_pulse_driver_if.sv
// sr_pulse_driver_if: button inputs and SR pulse outputs of the pulse driver
interface sr_pulse_driver_if;
    logic set_btn, reset_btn, S, R, q_model, busy, conflict;
    modport master(output set_btn, reset_btn, input S, R, q_model, busy, conflict);
    modport slave(input set_btn, reset_btn, output S, R, q_model, busy, conflict);
endinterface

// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: sync + debounce two buttons into clean S/R pulses for an SR flip-flop
// Index 0 of the per-input vectors is set, index 1 is reset.
module sr_pulse_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES = 1,
    parameter int CONFLICT_MODE = 0
) (
    input logic clk,
    input logic rst_n,
    sr_pulse_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;
    state_t state, state_n;
    logic [1:0] sync1, sync2, deb, pend, rise, clr;
    logic [1:0][7:0] dcnt;
    logic [3:0] pcnt, pcnt_n;
    logic act, act_n, q, q_n, conf, conf_n;
    always_comb begin
        for (int i = 0; i < 2; i++)
            rise[i] = sync2[i] & ~deb[i] & (dcnt[i] == 8'(DEBOUNCE_CYCLES - 1));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb <= '0;
            dcnt <= '0;
            pend <= '0;
        end else begin
            sync1 <= {bus.reset_btn, bus.set_btn};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) dcnt[i] <= '0;
                else if (rise[i] || dcnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i] <= ~deb[i];
                    dcnt[i] <= '0;
                end else dcnt[i] <= dcnt[i] + 8'd1;
            end
            // a rise landing on the same edge as a clear survives as a new request
            pend <= (pend & ~clr) | rise;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pcnt <= '0;
            act <= 1'b0;
            q <= 1'b0;
            conf <= 1'b0;
        end else begin
            state <= state_n;
            pcnt <= pcnt_n;
            act <= act_n;
            q <= q_n;
            conf <= conf_n;
        end
    end
    always_comb begin
        state_n = state;
        pcnt_n = pcnt;
        act_n = act;
        q_n = q;
        conf_n = 1'b0;
        clr = 2'b00;
        case (state)
            IDLE: begin
                if (pend != 2'b00) begin
                    clr = pend;
                    conf_n = &pend;
                    act_n = (&pend) ? (CONFLICT_MODE == 1) : pend[0];
                    if (!(&pend) || CONFLICT_MODE != 2) begin
                        state_n = PULSE;
                        pcnt_n = 4'(PULSE_CYCLES - 1);
                        q_n = act_n;
                    end
                end
            end
            PULSE: begin
                state_n = (pcnt == 4'd0) ? HOLDOFF : PULSE;
                pcnt_n = (pcnt == 4'd0) ? pcnt : pcnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end
    assign bus.S = (state == PULSE) & act;
    assign bus.R = (state == PULSE) & ~act;
    assign bus.busy = state != IDLE;
    assign bus.q_model = q;
    assign bus.conflict = conf;
endmodule
